// File: rtl/sdelay_pkg.sv
// sdelay_pkg
// Shared types and constants for the sdelay_line delay line.
//   sdelay_mode_e : runtime delay mode (transport / inertial)
//   REJ_CNT_W     : width of the rejected-pulse counter
package sdelay_pkg;

  typedef enum logic {
    MODE_TRANSPORT = 1'b0,
    MODE_INERTIAL  = 1'b1
  } sdelay_mode_e;

  localparam int REJ_CNT_W = 16;

endpackage

// File: rtl/sdelay_filter.sv
// sdelay_filter
// Single-bit stability filter. A new level on din is accepted into f only
// after it has been sampled MIN_PULSE edges in a row. A run that ends early
// is flagged on rej during the cycle in which din returns to f.
// In transport mode f simply follows din, so that switching to inertial
// mode starts from the last input level.
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset
//   din   in   raw input bit
//   mode  in   transport / inertial
//   f     out  filtered level (registered)
//   rej   out  a pending run is abandoned on this edge (combinational)
module sdelay_filter
  import sdelay_pkg::*;
#(
  parameter int MIN_PULSE = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din,
  input  sdelay_mode_e mode,
  output logic         f,
  output logic         rej
);

  localparam int CW = $clog2(MIN_PULSE + 1);
  localparam logic [CW-1:0] LAST = CW'(MIN_PULSE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f   <= 1'b0;
      cnt <= '0;
    end else if (mode != MODE_INERTIAL) begin
      // Bypassed, but tracking din keeps the inertial entry glitch-free
      f   <= din;
      cnt <= '0;
    end else if (din == f) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      f   <= din;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Dropping counts on a switch to transport is not a rejection
  assign rej = (mode == MODE_INERTIAL) && (din == f) && (cnt != '0);

endmodule

// File: rtl/sdelay_line.sv
// sdelay_line
// Clocked delay line for a WIDTH-bit bus with a runtime delay of 0..DEPTH-1
// extra cycles, in transport mode (every pulse passes) or inertial mode
// (per-bit pulses shorter than MIN_PULSE cycles are swallowed).
// Optional feature macro: SDELAY_REJ_CNT_EN
//   defined   : rej_cnt counts cycles with at least one rejected pulse,
//               saturating at all-ones
//   undefined : no counter, rej_cnt is tied to zero
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   din     in   data in, sampled every rising edge
//   dly     in   extra delay in cycles, clamped to DEPTH-1
//   mode    in   0 = transport, 1 = inertial
//   dout    out  delayed / filtered data (registered)
//   rej_cnt out  rejected-pulse cycle counter
module sdelay_line
  import sdelay_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int MIN_PULSE = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         din,
  input  logic [$clog2(DEPTH)-1:0] dly,
  input  logic                     mode,
  output logic [WIDTH-1:0]         dout,
  output logic [REJ_CNT_W-1:0]     rej_cnt
);

  localparam int DW = $clog2(DEPTH);

  sdelay_mode_e     mode_e;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] rej;
  logic [WIDTH-1:0] line_in;
  logic [WIDTH-1:0] sr  [DEPTH];
  logic [WIDTH-1:0] tap [DEPTH];
  logic [DW-1:0]    sel;

  assign mode_e = sdelay_mode_e'(mode);

  for (genvar g = 0; g < WIDTH; g++) begin : g_filt
    sdelay_filter #(
      .MIN_PULSE (MIN_PULSE)
    ) u_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din[g]),
      .mode  (mode_e),
      .f     (f[g]),
      .rej   (rej[g])
    );
  end

  assign line_in = (mode_e == MODE_INERTIAL) ? f : din;

  // tap[0] is the undelayed line so that dly=0 still yields one register
  always_comb begin
    tap[0] = line_in;
    for (int k = 1; k < DEPTH; k++) begin
      tap[k] = sr[k-1];
    end
  end

  // Only reachable when DEPTH is not a power of two
  always_comb begin
    sel = dly;
    if (32'(dly) > 32'(DEPTH - 1)) begin
      sel = DW'(DEPTH - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr[i] <= '0;
      end
      dout <= '0;
    end else begin
      sr[0] <= line_in;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
      dout <= tap[sel];
    end
  end

`ifdef SDELAY_REJ_CNT_EN
  // Several bits rejecting in the same cycle still count once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_cnt <= '0;
    end else if ((|rej) && (rej_cnt != '1)) begin
      rej_cnt <= rej_cnt + REJ_CNT_W'(1);
    end
  end
`else
  logic rej_unused;
  assign rej_unused = |rej;
  assign rej_cnt    = '0;
`endif

endmodule

// File: tb/tb_sdelay_line.sv
module tb_sdelay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int MP    = 3;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic [3:0]  dly;
  logic        mode;
  logic [7:0]  dout;
  logic [15:0] rej_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  sdelay_line #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .MIN_PULSE (MP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .dly     (dly),
    .mode    (mode),
    .dout    (dout),
    .rej_cnt (rej_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural reference model ----------------
  // Output = line value seen dly edges ago. Filtered level flips when the
  // last MP inertial samples all disagree with it; a rejection is an
  // inertial sample that agrees with the level right after one that did not.
  logic [7:0]  q_line [$];
  logic [7:0]  f_m;
  logic [7:0]  win_din [MP];
  logic        win_mode [MP];
  logic [15:0] rej_m;
  logic [7:0]  dout_m;

  task automatic model_reset();
    q_line = {};
    for (int k = 0; k < DEPTH; k++) q_line.push_back(8'h00);
    f_m = 8'h00;
    for (int j = 0; j < MP; j++) begin
      win_din[j]  = 8'h00;
      win_mode[j] = 1'b0;
    end
    rej_m  = 16'h0;
    dout_m = 8'h00;
  endtask

  task automatic model_edge(input logic [7:0] d, input logic [3:0] dl, input logic md);
    logic [7:0] line;
    logic [7:0] f_next;
    logic       any_rej;
    logic       acc;
    int         dsel;
    for (int j = MP - 1; j > 0; j--) begin
      win_din[j]  = win_din[j-1];
      win_mode[j] = win_mode[j-1];
    end
    win_din[0]  = d;
    win_mode[0] = md;
    line = md ? f_m : d;
    q_line.push_front(line);
    void'(q_line.pop_back());
    dsel   = (int'(dl) > DEPTH - 1) ? DEPTH - 1 : int'(dl);
    dout_m = q_line[dsel];
    any_rej = 1'b0;
    f_next  = d;
    if (md) begin
      f_next = f_m;
      for (int i = 0; i < WIDTH; i++) begin
        if (d[i] == f_m[i] && win_mode[1] && win_din[1][i] != f_m[i]) any_rej = 1'b1;
        acc = 1'b1;
        for (int j = 0; j < MP; j++)
          if (!win_mode[j] || win_din[j][i] == f_m[i]) acc = 1'b0;
        if (acc) f_next[i] = d[i];
      end
    end
    if (any_rej && rej_m != 16'hFFFF) rej_m = rej_m + 16'h1;
    f_m = f_next;
  endtask

  function automatic logic [15:0] rej_exp(input logic [15:0] v);
`ifdef SDELAY_REJ_CNT_EN
    return v;
`else
    return v & 16'h0000;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, advance the model, then land 1 after the edge.
  task automatic step(input logic [7:0] d, input logic [3:0] dl, input logic md);
    din  = d;
    dly  = dl;
    mode = md;
    model_edge(d, dl, md);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  din;
    logic [3:0]  dly;
    logic        mode;
    logic [7:0]  exp_dout;
    logic [15:0] exp_rej;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic [7:0] d, input logic [3:0] dl, input logic md,
                     input logic [7:0] ed, input logic [15:0] er);
    vec_t v;
    v.din = d; v.dly = dl; v.mode = md; v.exp_dout = ed; v.exp_rej = er;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] pat_d [8];
    logic [7:0] pat_e [8];
    logic [7:0] ind [15];
    logic [7:0] ine [15];
    logic [15:0] inr [15];

    // release with A5: 5 edges of latency at dly=4
    for (int k = 0; k < 4; k++) add(8'hA5, 4'd4, 1'b0, 8'h00, 16'd0);
    add(8'hA5, 4'd4, 1'b0, 8'hA5, 16'd0);
    // transport glitch train at dly=2
    add(8'h00, 4'd2, 1'b0, 8'hA5, 16'd0);
    add(8'h00, 4'd2, 1'b0, 8'hA5, 16'd0);
    add(8'h00, 4'd2, 1'b0, 8'h00, 16'd0);
    pat_d = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    pat_e = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
    for (int k = 0; k < 8; k++) add(pat_d[k], 4'd2, 1'b0, pat_e[k], 16'd0);
    // inertial: 1- and 2-cycle pulses rejected, 3-cycle pulse passes
    add(8'h00, 4'd0, 1'b1, 8'h00, 16'd0);
    add(8'h00, 4'd0, 1'b1, 8'h00, 16'd0);
    ind = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00,
            8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    ine = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    inr = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2,
            16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2};
    for (int k = 0; k < 15; k++) add(ind[k], 4'd0, 1'b1, ine[k], inr[k]);
    // all bits glitch together: one count
    add(8'hFF, 4'd0, 1'b1, 8'h00, 16'd2);
    add(8'h00, 4'd0, 1'b1, 8'h00, 16'd3);
    add(8'h00, 4'd0, 1'b1, 8'h00, 16'd3);

    // ---- reset held with toggling input ----
    rst_n = 1'b0;
    din   = 8'hFF;
    dly   = 4'd0;
    mode  = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      din = (k % 2 == 0) ? 8'hFF : 8'h00;
      @(posedge clk);
      #1;
      check("reset dout", 32'(dout), 32'h0);
      check("reset rej_cnt", 32'(rej_cnt), 32'h0);
    end
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].din, tbl[k].dly, tbl[k].mode);
      check($sformatf("vec%0d dout", k), 32'(dout), 32'(tbl[k].exp_dout));
      check($sformatf("vec%0d rej_cnt", k), 32'(rej_cnt), 32'(rej_exp(tbl[k].exp_rej)));
    end

    // ---- runtime dly change on a counting input ----
    for (int c = 16; c < 36; c++) step(8'(c), 4'd8, 1'b0);
    check("dly8 track", 32'(dout), 32'(35 - 8));
    step(8'd36, 4'd2, 1'b0);
    check("dly 8->2 jump", 32'(dout), 32'(36 - 2));
    step(8'd37, 4'd2, 1'b0);
    check("dly2 track", 32'(dout), 32'(37 - 2));
    step(8'd38, 4'd15, 1'b0);
    check("dly 2->15 repeat", 32'(dout), 32'(38 - 15));
    for (int c = 39; c < 46; c++) begin
      step(8'(c), 4'd15, 1'b0);
      check("dly15 track", 32'(dout), 32'(c - 15));
    end

    // ---- randomized run against the model ----
    begin
      logic [7:0] d  = 8'h00;
      logic [3:0] dl = 4'd0;
      logic       md = 1'b0;
      for (int n = 0; n < 600; n++) begin
        d = d ^ (8'($urandom) & 8'($urandom));
        if ($urandom_range(0, 15) == 0) dl = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 31) == 0) md = ~md;
        step(d, dl, md);
        check("rand dout", 32'(dout), 32'(dout_m));
        check("rand rej_cnt", 32'(rej_cnt), 32'(rej_exp(rej_m)));
      end
    end

    // ---- saturation: alternating bits reject on every edge ----
    step(8'h00, 4'd0, 1'b1);
    step(8'h00, 4'd0, 1'b1);
    for (int n = 0; n < 65545; n++) step((n % 2 == 0) ? 8'h01 : 8'h02, 4'd0, 1'b1);
    check("sat rej_cnt", 32'(rej_cnt), 32'(rej_exp(16'hFFFF)));
    check("sat rej_cnt model", 32'(rej_cnt), 32'(rej_exp(rej_m)));
    for (int n = 0; n < 3; n++) step(8'h00, 4'd0, 1'b1);
    for (int n = 0; n < 5; n++) step(8'hFF, 4'd0, 1'b1);
    check("accepted FF", 32'(dout), 32'hFF);
    check("rej_cnt held", 32'(rej_cnt), 32'(rej_exp(16'hFFFF)));

    // ---- async reset mid-pulse ----
    step(8'h00, 4'd0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst dout", 32'(dout), 32'h0);
    check("async rst rej_cnt", 32'(rej_cnt), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(8'h00, 4'd0, 1'b1);
    check("post rst dout", 32'(dout), 32'(dout_m));
    step(8'h3C, 4'd0, 1'b0);
    check("post rst transport", 32'(dout), 32'h3C);
    check("post rst rej_cnt", 32'(rej_cnt), 32'(rej_exp(rej_m)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
